am2901_slice_w: RTL and testbench

Parametrised successor to the 4-bit Am2901 bit-slice. It implements the same 9-bit microinstruction set (source, function and destination fields) over a configurable data width and register-file depth. It adds asynchronous reset of all state, a clock enable, and a registered status-flag word. It is the datapath core driven by the microsequencer: one microinstruction per enabled CLK edge.

---
 rtl/am2901_slice_w.sv | 259 +++++++++++++++++++++++++
 tb/tb_am2901_slice_w.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am2901_slice_w.sv
// am2901_slice_w
//   Parametrised Am2901-style bit-slice datapath. One 9-bit microinstruction
//   {dest, func, src} is executed per enabled rising CLK edge.
//
//   Parameters
//     WIDTH  datapath width (>= 4)
//     DEPTH  register-file words (power of 2, >= 2); AW = log2(DEPTH)
//
//   Ports
//     CLK, RST_N       clock, asynchronous active-low reset (clears RAM, Q, FLAGS)
//     CE               clock enable for every state element
//     A, B             RAM read address A, read/write address B
//     D                external data operand
//     I                microinstruction {I[8:6] dest, I[5:3] func, I[2:0] src}
//     CN               ALU carry-in
//     FLAG_WE          latch {Z,N,C,V} into FLAGS this cycle (qualified by CE)
//     RAM0_IN/RAMM_IN  RAM shifter fill bits (LSB on up-shift, MSB on down-shift)
//     Q0_IN/QM_IN      Q shifter fill bits
//     Y                result bus
//     G_N, P_N         active-low group generate / propagate
//     CN_OUT, OVR      carry out of MSB, signed overflow
//     F_ZERO, F_MSB    ALU result zero / sign
//     *_OUT, *_EN      shifter bits leaving the slice and their valid strobes
//     FLAGS            registered {Z, N, C, V}
module am2901_slice_w #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic [AW-1:0]    A,
    input  logic [AW-1:0]    B,
    input  logic [WIDTH-1:0] D,
    input  logic [8:0]       I,
    input  logic             CN,
    input  logic             FLAG_WE,
    input  logic             RAM0_IN,
    input  logic             RAMM_IN,
    input  logic             Q0_IN,
    input  logic             QM_IN,
    output logic [WIDTH-1:0] Y,
    output logic             G_N,
    output logic             P_N,
    output logic             CN_OUT,
    output logic             OVR,
    output logic             F_ZERO,
    output logic             F_MSB,
    output logic             RAM0_OUT,
    output logic             RAMM_OUT,
    output logic             Q0_OUT,
    output logic             QM_OUT,
    output logic             RAM0_EN,
    output logic             RAMM_EN,
    output logic             Q0_EN,
    output logic             QM_EN,
    output logic [3:0]       FLAGS
);

    typedef enum logic [2:0] {
        SRC_AQ, SRC_AB, SRC_ZQ, SRC_ZB, SRC_ZA, SRC_DA, SRC_DQ, SRC_DZ
    } src_e;

    typedef enum logic [2:0] {
        FN_ADD, FN_SUBR, FN_SUBS, FN_OR, FN_AND, FN_NOTRS, FN_EXOR, FN_EXNOR
    } fn_e;

    typedef enum logic [2:0] {
        DST_QREG, DST_NOP, DST_RAMA, DST_RAMF, DST_RAMQD, DST_RAMD, DST_RAMQU, DST_RAMU
    } dst_e;

    // State
    logic [WIDTH-1:0] r_ram [DEPTH];
    logic [WIDTH-1:0] r_q;
    logic [3:0]       r_flags;

    // Decode
    src_e w_src;
    fn_e  w_fn;
    dst_e w_dst;

    assign w_src = src_e'(I[2:0]);
    assign w_fn  = fn_e'(I[5:3]);
    assign w_dst = dst_e'(I[8:6]);

    // Read ports: always the pre-edge contents
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    assign w_a = r_ram[A];
    assign w_b = r_ram[B];

    // Operand selection
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_s;

    always_comb begin
        w_r = '0;
        w_s = '0;
        case (w_src)
            SRC_AQ:  begin w_r = w_a; w_s = r_q; end
            SRC_AB:  begin w_r = w_a; w_s = w_b; end
            SRC_ZQ:  begin w_r = '0;  w_s = r_q; end
            SRC_ZB:  begin w_r = '0;  w_s = w_b; end
            SRC_ZA:  begin w_r = '0;  w_s = w_a; end
            SRC_DA:  begin w_r = D;   w_s = w_a; end
            SRC_DQ:  begin w_r = D;   w_s = r_q; end
            SRC_DZ:  begin w_r = D;   w_s = '0;  end
            default: begin w_r = '0;  w_s = '0;  end
        endcase
    end

    // Adder operands: subtraction is done by inverting one side and using CN
    logic             w_arith;
    logic [WIDTH-1:0] w_op_r;
    logic [WIDTH-1:0] w_op_s;

    assign w_arith = (w_fn == FN_ADD) || (w_fn == FN_SUBR) || (w_fn == FN_SUBS);

    always_comb begin
        w_op_r = w_r;
        w_op_s = w_s;
        if (w_fn == FN_SUBR) w_op_r = ~w_r;
        if (w_fn == FN_SUBS) w_op_s = ~w_s;
    end

    logic [WIDTH:0] w_sum;
    logic           w_c_msb_in;
    logic           w_gen;
    logic           w_prop;

    assign w_sum = {1'b0, w_op_r} + {1'b0, w_op_s} + {{WIDTH{1'b0}}, CN};

    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin
    assign w_c_msb_in = w_sum[WIDTH-1] ^ w_op_r[WIDTH-1] ^ w_op_s[WIDTH-1];

    // Group generate: ripple of per-bit generate/propagate with carry-in 0
    always_comb begin
        w_gen = 1'b0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            w_gen = (w_op_r[k] & w_op_s[k]) | ((w_op_r[k] | w_op_s[k]) & w_gen);
        end
    end

    assign w_prop = &(w_op_r | w_op_s);

    // ALU result
    logic [WIDTH-1:0] w_f;

    always_comb begin
        w_f = '0;
        case (w_fn)
            FN_ADD, FN_SUBR, FN_SUBS: w_f = w_sum[WIDTH-1:0];
            FN_OR:    w_f = w_r | w_s;
            FN_AND:   w_f = w_r & w_s;
            FN_NOTRS: w_f = ~w_r & w_s;
            FN_EXOR:  w_f = w_r ^ w_s;
            FN_EXNOR: w_f = ~(w_r ^ w_s);
            default:  w_f = '0;
        endcase
    end

    assign CN_OUT = w_arith & w_sum[WIDTH];
    assign OVR    = w_arith & (w_c_msb_in ^ w_sum[WIDTH]);
    assign G_N    = ~(w_arith & w_gen);
    assign P_N    = ~(w_arith & w_prop);
    assign F_ZERO = (w_f == '0);
    assign F_MSB  = w_f[WIDTH-1];

    assign Y = (w_dst == DST_RAMA) ? w_a : w_f;

    // Destination control: write data, write enables, shift-out bits
    logic             w_ram_we;
    logic             w_q_we;
    logic [WIDTH-1:0] w_ram_wd;
    logic [WIDTH-1:0] w_q_wd;

    always_comb begin
        w_ram_we = 1'b0;
        w_q_we   = 1'b0;
        w_ram_wd = w_f;
        w_q_wd   = w_f;
        RAM0_OUT = 1'b0;
        RAMM_OUT = 1'b0;
        Q0_OUT   = 1'b0;
        QM_OUT   = 1'b0;
        RAM0_EN  = 1'b0;
        RAMM_EN  = 1'b0;
        Q0_EN    = 1'b0;
        QM_EN    = 1'b0;
        case (w_dst)
            DST_QREG: begin
                w_q_we = 1'b1;
            end
            DST_NOP: begin
            end
            DST_RAMA, DST_RAMF: begin
                w_ram_we = 1'b1;
            end
            DST_RAMQD, DST_RAMD: begin
                w_ram_we = 1'b1;
                w_ram_wd = {RAMM_IN, w_f[WIDTH-1:1]};
                RAM0_EN  = 1'b1;
                RAM0_OUT = w_f[0];
                if (w_dst == DST_RAMQD) begin
                    w_q_we = 1'b1;
                    w_q_wd = {QM_IN, r_q[WIDTH-1:1]};
                    Q0_EN  = 1'b1;
                    Q0_OUT = r_q[0];
                end
            end
            DST_RAMQU, DST_RAMU: begin
                w_ram_we = 1'b1;
                w_ram_wd = {w_f[WIDTH-2:0], RAM0_IN};
                RAMM_EN  = 1'b1;
                RAMM_OUT = w_f[WIDTH-1];
                if (w_dst == DST_RAMQU) begin
                    w_q_we = 1'b1;
                    w_q_wd = {r_q[WIDTH-2:0], Q0_IN};
                    QM_EN  = 1'b1;
                    QM_OUT = r_q[WIDTH-1];
                end
            end
            default: begin
            end
        endcase
    end

    // Register file: flop array so every word clears on reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_ram[i] <= '0;
            end
        end else if (CE && w_ram_we) begin
            r_ram[B] <= w_ram_wd;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_q <= '0;
        end else if (CE && w_q_we) begin
            r_q <= w_q_wd;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_flags <= '0;
        end else if (CE && FLAG_WE) begin
            r_flags <= {F_ZERO, F_MSB, CN_OUT, OVR};
        end
    end

    assign FLAGS = r_flags;

endmodule

// File: tb/tb_am2901_slice_w.sv
// tb_am2901_slice_w
//   Directed-vector bench for am2901_slice_w (WIDTH=8, DEPTH=16). A
//   behavioural model of the register file, Q and flags is evaluated with
//   plain integer arithmetic and compared against every DUT output on each
//   falling clock edge; hand-computed literal checks pin the model.
module tb_am2901_slice_w;

    localparam int W     = 8;
    localparam int DEP   = 16;
    localparam int unsigned MASK = 255;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       CE;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] D;
    logic [8:0] I;
    logic       CN;
    logic       FLAG_WE;
    logic       RAM0_IN, RAMM_IN, Q0_IN, QM_IN;
    logic [7:0] Y;
    logic       G_N, P_N, CN_OUT, OVR, F_ZERO, F_MSB;
    logic       RAM0_OUT, RAMM_OUT, Q0_OUT, QM_OUT;
    logic       RAM0_EN, RAMM_EN, Q0_EN, QM_EN;
    logic [3:0] FLAGS;

    int n_cmp = 0;
    int n_bad = 0;

    am2901_slice_w #(.WIDTH(W), .DEPTH(DEP)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .A(A), .B(B), .D(D), .I(I),
        .CN(CN), .FLAG_WE(FLAG_WE),
        .RAM0_IN(RAM0_IN), .RAMM_IN(RAMM_IN), .Q0_IN(Q0_IN), .QM_IN(QM_IN),
        .Y(Y), .G_N(G_N), .P_N(P_N), .CN_OUT(CN_OUT), .OVR(OVR),
        .F_ZERO(F_ZERO), .F_MSB(F_MSB),
        .RAM0_OUT(RAM0_OUT), .RAMM_OUT(RAMM_OUT), .Q0_OUT(Q0_OUT), .QM_OUT(QM_OUT),
        .RAM0_EN(RAM0_EN), .RAMM_EN(RAMM_EN), .Q0_EN(Q0_EN), .QM_EN(QM_EN),
        .FLAGS(FLAGS)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    int unsigned m_ram [DEP];
    int unsigned m_q = 0;
    logic [3:0]  m_flags = 4'h0;

    initial foreach (m_ram[i]) m_ram[i] = 0;

    typedef struct {
        int unsigned y;
        int unsigned f;
        bit g_n, p_n, cout, ovr, fz, fm;
        bit r0o, rmo, q0o, qmo, r0e, rme, q0e, qme;
        bit ram_we, q_we;
        int unsigned ram_wd, q_wd;
    } exp_t;

    function automatic int sx(int unsigned x);
        return (x >= 128) ? int'(x) - 256 : int'(x);
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        int unsigned ra, rb, r, s, o1, o2, f, sum;
        int sr;
        int unsigned dst, fn, sc;
        e = '{default: 0};
        dst = int'(I[8:6]);
        fn  = int'(I[5:3]);
        sc  = int'(I[2:0]);
        ra = m_ram[A];
        rb = m_ram[B];
        r = 0; s = 0; f = 0;
        case (sc)
            0: begin r = ra; s = m_q; end
            1: begin r = ra; s = rb;  end
            2: begin r = 0;  s = m_q; end
            3: begin r = 0;  s = rb;  end
            4: begin r = 0;  s = ra;  end
            5: begin r = int'(D); s = ra;  end
            6: begin r = int'(D); s = m_q; end
            default: begin r = int'(D); s = 0; end
        endcase
        e.g_n = 1; e.p_n = 1;
        if (fn <= 2) begin
            o1 = (fn == 1) ? (~r & MASK) : r;
            o2 = (fn == 2) ? (~s & MASK) : s;
            sum = o1 + o2 + int'(CN);
            f = sum & MASK;
            e.cout = (sum > MASK);
            sr = sx(o1) + sx(o2) + int'(CN);
            e.ovr = (sr > 127) || (sr < -128);
            e.g_n = !((o1 + o2) > MASK);
            e.p_n = !((o1 | o2) == MASK);
        end else begin
            case (fn)
                3: f = r | s;
                4: f = r & s;
                5: f = ~r & s & MASK;
                6: f = r ^ s;
                default: f = ~(r ^ s) & MASK;
            endcase
        end
        e.f  = f;
        e.fz = (f == 0);
        e.fm = (f >= 128);
        e.y  = (dst == 2) ? ra : f;
        e.ram_we = (dst >= 2);
        e.q_we   = (dst == 0) || (dst == 4) || (dst == 6);
        e.ram_wd = f;
        e.q_wd   = f;
        if (dst == 4 || dst == 5) begin
            e.ram_wd = int'(RAMM_IN) * 128 + f / 2;
            e.r0e = 1; e.r0o = f[0];
            if (dst == 4) begin
                e.q_wd = int'(QM_IN) * 128 + m_q / 2;
                e.q0e = 1; e.q0o = m_q[0];
            end
        end
        if (dst == 6 || dst == 7) begin
            e.ram_wd = (f * 2 + int'(RAM0_IN)) & MASK;
            e.rme = 1; e.rmo = (f >= 128);
            if (dst == 6) begin
                e.q_wd = (m_q * 2 + int'(Q0_IN)) & MASK;
                e.qme = 1; e.qmo = (m_q >= 128);
            end
        end
        return e;
    endfunction

    always @(negedge RST_N) begin
        foreach (m_ram[i]) m_ram[i] = 0;
        m_q = 0;
        m_flags = 4'h0;
    end

    always @(posedge CLK) begin
        exp_t e;
        if (RST_N === 1'b1 && CE === 1'b1) begin
            e = model_eval();
            if (e.ram_we) m_ram[B] = e.ram_wd;
            if (e.q_we) m_q = e.q_wd;
            if (FLAG_WE === 1'b1) m_flags = {e.fz, e.fm, e.cout, e.ovr};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t I=%o A=%0d B=%0d D=%0h)",
                     nm, act, req, $time, I, A, B, D);
        end
    endtask

    // Compare process: every falling edge, all outputs against the model
    always @(negedge CLK) begin
        exp_t e;
        e = model_eval();
        chk("Y", {24'h0, Y}, e.y);
        chk("status", {26'h0, G_N, P_N, CN_OUT, OVR, F_ZERO, F_MSB},
            {26'h0, e.g_n, e.p_n, e.cout, e.ovr, e.fz, e.fm});
        chk("shift", {24'h0, RAM0_OUT, RAMM_OUT, Q0_OUT, QM_OUT, RAM0_EN, RAMM_EN, Q0_EN, QM_EN},
            {24'h0, e.r0o, e.rmo, e.q0o, e.qmo, e.r0e, e.rme, e.q0e, e.qme});
        chk("FLAGS", {28'h0, FLAGS}, {28'h0, m_flags});
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic op(input logic [8:0] ins, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] d, input logic cn);
        I = ins; A = a; B = b; D = d; CN = cn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; CE = 1'b1; FLAG_WE = 1'b0;
        RAM0_IN = 0; RAMM_IN = 0; Q0_IN = 0; QM_IN = 0;
        op(9'o000, 0, 0, 8'h00, 0);
        tick(); tick();
        #1;
        chk("reset_flags", {28'h0, FLAGS}, 32'h0);
        chk("reset_y", {24'h0, Y}, 32'h0);
        RST_N = 1'b1;
        tick();

        // preload R5, Q and non-zero flags
        op(9'o307, 0, 5, 8'h3C, 0); tick();
        op(9'o007, 0, 0, 8'h11, 0); tick();
        FLAG_WE = 1; op(9'o107, 0, 0, 8'h80, 0); tick(); FLAG_WE = 0;
        #1 chk("flags_preload", {28'h0, FLAGS}, 32'h4);
        op(9'o134, 5, 0, 8'h00, 0); #1 chk("r5_preload", {24'h0, Y}, 32'h3C);
        tick();

        // asynchronous reset between edges
        RST_N = 1'b0;
        op(9'o134, 5, 0, 8'h00, 0); #1 chk("r5_reset", {24'h0, Y}, 32'h0);
        op(9'o132, 0, 0, 8'h00, 0); #1 chk("q_reset", {24'h0, Y}, 32'h0);
        chk("flags_reset", {28'h0, FLAGS}, 32'h0);
        #2 RST_N = 1'b1;
        tick();
        op(9'o137, 0, 0, 8'hA5, 0); #1 chk("pass_d_or", {24'h0, Y}, 32'hA5);
        op(9'o177, 0, 0, 8'hA5, 0); #1 chk("pass_d_xnor", {24'h0, Y}, 32'h5A);
        tick();

        // overflow
        op(9'o307, 0, 3, 8'h7F, 0); tick();
        FLAG_WE = 1; op(9'o104, 3, 0, 8'h00, 1);
        #1 chk("ovr_y", {24'h0, Y}, 32'h80);
        chk("ovr_bits", {29'h0, OVR, F_MSB, CN_OUT}, 32'b110);
        tick(); FLAG_WE = 0;
        #1 chk("ovr_flags", {28'h0, FLAGS}, 32'b0101);

        // subtract with borrow, and exact zero
        op(9'o307, 0, 1, 8'h05, 0); tick();
        op(9'o307, 0, 2, 8'h07, 0); tick();
        op(9'o111, 2, 1, 8'h00, 1);
        #1 chk("sub_y", {24'h0, Y}, 32'hFE);
        chk("sub_bits", {29'h0, CN_OUT, OVR, F_ZERO}, 32'b000);
        op(9'o111, 1, 1, 8'h00, 1);
        #1 chk("sub_zero", {29'h0, CN_OUT, OVR, F_ZERO}, 32'b101);
        tick();

        // down-shift
        op(9'o307, 0, 4, 8'h81, 0); tick();
        op(9'o007, 0, 0, 8'h02, 0); tick();
        RAMM_IN = 1; QM_IN = 0;
        op(9'o403, 0, 4, 8'h00, 0);
        #1 chk("dn_out", {28'h0, RAM0_EN, RAM0_OUT, Q0_EN, Q0_OUT}, 32'b1110);
        tick(); RAMM_IN = 0;
        op(9'o134, 4, 0, 8'h00, 0); #1 chk("dn_r4", {24'h0, Y}, 32'hC0);
        op(9'o132, 0, 0, 8'h00, 0); #1 chk("dn_q", {24'h0, Y}, 32'h01);
        tick();

        // up-shift without and with Q
        RAM0_IN = 1; Q0_IN = 1;
        op(9'o703, 0, 4, 8'h00, 0);
        #1 chk("up_out", {29'h0, RAMM_EN, RAMM_OUT, QM_EN}, 32'b110);
        tick();
        op(9'o134, 4, 0, 8'h00, 0); #1 chk("up_r4", {24'h0, Y}, 32'h81);
        op(9'o132, 0, 0, 8'h00, 0); #1 chk("up_q_hold", {24'h0, Y}, 32'h01);
        tick();
        RAM0_IN = 0;
        op(9'o603, 0, 4, 8'h00, 0);
        #1 chk("upq_out", {30'h0, QM_EN, QM_OUT}, 32'b10);
        tick(); Q0_IN = 0;
        op(9'o134, 4, 0, 8'h00, 0); #1 chk("upq_r4", {24'h0, Y}, 32'h02);
        op(9'o132, 0, 0, 8'h00, 0); #1 chk("upq_q", {24'h0, Y}, 32'h03);
        tick();

        // clock enable and read-during-write
        CE = 0; op(9'o307, 0, 6, 8'h55, 0); tick();
        CE = 1; op(9'o134, 6, 0, 8'h00, 0); #1 chk("ce_hold", {24'h0, Y}, 32'h00);
        op(9'o207, 6, 6, 8'h55, 0); #1 chk("rdw_old", {24'h0, Y}, 32'h00);
        tick();
        #1 chk("rdw_new", {24'h0, Y}, 32'h55);
        tick();

        // reset held across an edge discards the pending write
        op(9'o307, 0, 7, 8'h99, 0);
        RST_N = 1'b0; tick(); RST_N = 1'b1;
        op(9'o134, 7, 0, 8'h00, 0); #1 chk("rst_discard", {24'h0, Y}, 32'h00);
        tick();

        // sweep of every {dest, func, src} with varied data; model checks all
        for (int k = 0; k < 512; k++) begin
            logic [8:0] ins;
            ins = 9'(k);
            op(ins, 4'(k * 7), 4'(k * 3 + 1), 8'(k * 37 + 11), k[0]);
            FLAG_WE = k[1];
            RAM0_IN = k[2]; RAMM_IN = k[3]; Q0_IN = k[4]; QM_IN = k[5];
            CE = (k % 11 != 0);
            tick();
        end
        CE = 1; FLAG_WE = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
